// File: rtl/cla_pkg.sv
// Shared definitions for the iterative carry-lookahead adder: group width,
// FSM states and the 4-bit group propagate/generate reduction.
package cla_pkg;

  localparam int GROUP_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Returns {pg, gg} for one 4-bit group from its per-bit p/g terms.
  function automatic logic [1:0] group_pg(input logic [GROUP_W-1:0] p,
                                          input logic [GROUP_W-1:0] g);
    logic pg;
    logic gg;
    pg = &p;
    gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    return {pg, gg};
  endfunction

endpackage

// File: rtl/pg_lookahead4.sv
// Combinational 4-bit lookahead stage: per-bit p/g, lookahead carries c1..c4,
// the sum nibble and the group propagate/generate.
module pg_lookahead4
  import cla_pkg::*;
(
  input  logic [GROUP_W-1:0] a4,
  input  logic [GROUP_W-1:0] b4,
  input  logic               c0,
  output logic [GROUP_W-1:0] s4,
  output logic [4:1]         c,
  output logic               pg,
  output logic               gg
);

  logic [GROUP_W-1:0] p;
  logic [GROUP_W-1:0] g;

  always_comb begin
    p    = a4 ^ b4;
    g    = a4 & b4;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c0);
    s4   = p ^ {c[3:1], c0};
    {pg, gg} = group_pg(p, g);
  end

endmodule

// File: rtl/cla_iter_adder.sv
// Sequential carry-lookahead adder: one 4-bit group is resolved per clock
// through a single shared lookahead stage, with valid/ready on both sides.
module cla_iter_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             pout,
  output logic             gout,
  output logic [1:0]       dbg_state
);

  localparam int GROUPS = WIDTH / GROUP_W;
  localparam int IDX_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid holds its payload stable until that edge.

  state_t               state;
  logic [IDX_W-1:0]     idx;
  logic                 carry;
  logic                 p_acc;
  logic                 g_acc;
  logic [WIDTH-1:0]     a_r;
  logic [WIDTH-1:0]     b_r;

  logic [GROUP_W-1:0]   a4;
  logic [GROUP_W-1:0]   b4;
  logic [GROUP_W-1:0]   s4;
  logic [4:1]           c;
  logic                 pg;
  logic                 gg;
  logic                 last;

  always_comb begin
    a4 = '0;
    b4 = '0;
    for (int g = 0; g < GROUPS; g++) begin
      if (idx == IDX_W'(g)) begin
        a4 = a_r[g*GROUP_W +: GROUP_W];
        b4 = b_r[g*GROUP_W +: GROUP_W];
      end
    end
  end

  pg_lookahead4 u_la (
    .a4 (a4),
    .b4 (b4),
    .c0 (carry),
    .s4 (s4),
    .c  (c),
    .pg (pg),
    .gg (gg)
  );

  assign last      = (idx == IDX_W'(GROUPS - 1));
  assign in_ready  = (state == IDLE) && !rst;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      carry     <= 1'b0;
      p_acc     <= 1'b1;
      g_acc     <= 1'b0;
      a_r       <= '0;
      b_r       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      pout      <= 1'b0;
      gout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r   <= a;
            b_r   <= b;
            carry <= cin;
            idx   <= '0;
            p_acc <= 1'b1;
            g_acc <= 1'b0;
            state <= CALC;
          end
        end
        CALC: begin
          for (int g = 0; g < GROUPS; g++) begin
            if (idx == IDX_W'(g)) sum[g*GROUP_W +: GROUP_W] <= s4;
          end
          carry <= c[4];
          p_acc <= p_acc & pg;
          g_acc <= gg | (pg & g_acc);
          if (last) begin
            cout      <= c[4];
            ovf       <= c[3] ^ c[4];
            pout      <= p_acc & pg;
            gout      <= gg | (pg & g_acc);
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cla_iter_adder.sv
// Bench for cla_iter_adder: directed vectors, latency/back-pressure, mid-op
// reset and randomized traffic checked against an arithmetic reference.
module tb_cla_iter_adder;
  import cla_pkg::*;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         pout;
  logic         gout;
  logic [1:0]   dbg_state;

  int checks = 0;
  int errors = 0;
  int mode   = 0;  // out_ready policy: 0 always, 1 random, 2 held low

  // Packed as {sum, cout, ovf, pout, gout}.
  logic [W+3:0] exp_q[$];

  cla_iter_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .pout      (pout),
    .gout      (gout),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W+3:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mc);
    logic [W:0]   full;
    logic [W:0]   nocin;
    logic [W-1:0] s;
    logic         o;
    full  = {1'b0, ma} + {1'b0, mb} + (W+1)'(mc);
    nocin = {1'b0, ma} + {1'b0, mb};
    s     = full[W-1:0];
    o     = (ma[W-1] == mb[W-1]) && (s[W-1] != ma[W-1]);
    return {s, full[W], o, &(ma ^ mb), nocin[W]};
  endfunction

  // Called just after a falling edge; returns just after the falling edge
  // that follows the accepting rising edge.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
    int budget;
    budget   = 0;
    a        = ta;
    b        = tb;
    cin      = tc;
    in_valid = 1'b1;
    while (!in_ready) begin
      @(negedge clk);
      budget++;
      if (budget > 200) begin
        check("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        return;
      end
    end
    exp_q.push_back(model(ta, tb, tc));
    @(negedge clk);
    in_valid = 1'b0;
    a        = W'($urandom);
    b        = W'($urandom);
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return {1'b1, {(W-1){1'b0}}};
      3:       return {1'b0, {(W-1){1'b1}}};
      default: return W'($urandom);
    endcase
  endfunction

  // Monitor: drives out_ready, pops the scoreboard on every output handshake
  // and checks that a stalled result stays put.
  initial begin
    logic         hold_prev;
    logic [W+3:0] held;
    logic [W+3:0] e;
    hold_prev = 1'b0;
    held      = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_prev = 1'b0;
        out_ready = 1'b0;
        continue;
      end
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b0;
      endcase
      if (hold_prev) begin
        check("valid_held", {31'd0, out_valid}, 32'd1);
        check("hold_stable", {12'd0, sum, cout, ovf, pout, gout}, {12'd0, held});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("sum",  {16'd0, sum},  {16'd0, e[W+3:4]});
          check("cout", {31'd0, cout}, {31'd0, e[3]});
          check("ovf",  {31'd0, ovf},  {31'd0, e[2]});
          check("pout", {31'd0, pout}, {31'd0, e[1]});
          check("gout", {31'd0, gout}, {31'd0, e[0]});
        end
        hold_prev = 1'b0;
      end else begin
        hold_prev = out_valid;
        held      = {sum, cout, ovf, pout, gout};
      end
    end
  end

  initial begin
    int lat;
    int budget;
    logic seen;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_in_ready",  {31'd0, in_ready},  32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_outputs",   {12'd0, sum, cout, ovf, pout, gout}, 32'd0);
    check("rst_state",     {30'd0, dbg_state}, {30'd0, IDLE});
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", {31'd0, in_ready}, 32'd1);

    // Directed vectors
    mode = 0;
    send(16'hFFFF, 16'h0001, 1'b0);
    send(16'h7FFF, 16'h0001, 1'b0);
    send(16'h5555, 16'hAAAA, 1'b1);
    send(16'h8000, 16'h8000, 1'b0);
    send(16'hFFFF, 16'h0000, 1'b1);

    // Latency and back-pressure
    while (out_valid || !in_ready) @(negedge clk);
    mode = 2;
    @(negedge clk);
    send(16'h1234, 16'h4321, 1'b0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, 32'd4);
    check("lat_sum", {16'd0, sum}, 32'h5555);
    for (int k = 0; k < 3; k++) begin
      a        = W'($urandom);
      b        = W'($urandom);
      in_valid = 1'b1;
      check("hold_in_ready",  {31'd0, in_ready},  32'd0);
      check("hold_out_valid", {31'd0, out_valid}, 32'd1);
      check("hold_sum",       {16'd0, sum},       32'h5555);
      @(negedge clk);
    end
    in_valid = 1'b0;
    mode     = 0;
    budget   = 0;
    while (out_valid && budget < 10) begin
      @(negedge clk);
      budget++;
    end
    check("release_out_valid", {31'd0, out_valid}, 32'd0);
    check("post_hs_in_ready",  {31'd0, in_ready},  32'd1);

    // Reset two cycles into CALC
    @(negedge clk);
    send(16'hBEEF, 16'h1357, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_outputs",   {12'd0, sum, cout, ovf, pout, gout}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("postrst_in_ready", {31'd0, in_ready}, 32'd1);
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      seen |= out_valid;
      @(negedge clk);
    end
    check("abandoned_no_valid", {31'd0, seen}, 32'd0);

    // Random traffic with random stalls
    mode = 1;
    for (int i = 0; i < 1000; i++) begin
      send(pick_operand(), pick_operand(), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Drain
    budget = 0;
    while ((exp_q.size() != 0 || out_valid) && budget < 2000) begin
      @(negedge clk);
      budget++;
    end
    check("drain_queue_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cla_iter_adder.md
# cla_iter_adder

Multi-cycle carry-lookahead adder that produces per-bit propagate/generate terms and resolves carries one 4-bit group per clock through a 4-bit lookahead stage. It accepts one operand pair via a valid/ready handshake and returns the sum, carry-out, signed overflow and block-level propagate/generate (pout/gout), also via valid/ready. It sits in the datapath as the sequential, area-lean alternative to the flat combinational lookahead adder. It also serves as a golden source of group P/G/carry values for the lookahead-unit benches.

## Interface
- WIDTH, 16, operand width; must be a multiple of 4, minimum 4
- GROUPS, WIDTH/4, derived; not overridable
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operands
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  a + b + cin, low WIDTH bits
- cout  out  1  carry out of bit WIDTH-1
- ovf  out  1  signed overflow: carry into MSB XOR cout
- pout  out  1  block propagate: AND of all a[i]^b[i]
- gout  out  1  block generate: carry out with cin=0

## Operation
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: latch a, b, cin; set idx=0, carry=cin, P_acc=1, G_acc=0; go to CALC.
- CALC: one group per cycle, group idx = bits [4*idx+3 : 4*idx].
  - Per bit: p=a^b, g=a&b.
  - Group carries c1..c4 come from lookahead on carry: c1=g0|p0c0, c2=g1|p1g0|p1p0c0, and so on.
  - Write sum nibble idx.
  - Update carry ← c4, P_acc ← P_acc & PG, G_acc ← GG | (PG & G_acc), where PG/GG are the group propagate/generate.
  - On idx==GROUPS-1:
    - cout ← c4
    - ovf ← c3 ^ c4
    - pout ← P_acc & PG
    - gout ← GG | (PG & G_acc)
    - go to DONE.
  - Otherwise idx+1.
- DONE:
  - out_valid=1; all result outputs held stable.
  - On out_ready go to IDLE.
- in_valid is ignored outside IDLE. in_ready=0 in CALC and DONE. No overlap of operations.
- Arithmetic is unsigned modulo 2^WIDTH. ovf treats operands as two's complement.
- Reset:
  - State → IDLE; idx, carry and all outputs → 0, including sum, cout, ovf, pout, gout and out_valid.
  - in_ready is 0 while rst is high.
  - Reset mid-CALC or mid-DONE abandons the operation; no out_valid is produced for it.

## Timing
- All outputs are registered except in_ready, which is decoded from state.
- Latency: operands accepted at edge N → out_valid high after edge N+GROUPS (4 cycles for WIDTH=16).
- sum nibbles update progressively during CALC. Only the values present while out_valid=1 are defined.
- out_valid stays high until the out_ready handshake edge; it is low the next cycle, with in_ready=1.
- Throughput: one operation per GROUPS+2 cycles when out_ready is held at 1.
- in_valid and out_ready may change any cycle; only the sampled edge matters.

## Structure
- Package cla_pkg holds:
  - GROUP_W=4
  - state enum {IDLE, CALC, DONE}
  - function computing group PG/GG from 4-bit p/g.
- Sub-module pg_lookahead4 (combinational):
  - Inputs: a4, b4, c0.
  - Outputs: s4, c[4:1], PG, GG.
  - Instantiated once and reused each CALC cycle.
- Top contains the FSM, idx counter (width clog2(GROUPS), min 1), operand and result registers, and P/G accumulators.

## Test plan
- a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, ovf=0, pout=0, gout=1.
- a=0x7FFF, b=0x0001, cin=0 → sum=0x8000, cout=0, ovf=1, pout=0, gout=0.
- a=0x5555, b=0xAAAA, cin=1 → sum=0x0000, cout=1, ovf=0, pout=1, gout=0.
- Latency/back-pressure:
  - Accept a=0x1234, b=0x4321 at edge N → out_valid rises after edge N+4, sum=0x5555.
  - Hold out_ready=0 for 3 cycles → outputs stable, in_ready=0.
  - New in_valid ignored during the hold.
  - After the handshake, in_ready=1 on the next cycle.
- Reset mid-operation: assert rst two cycles into CALC → out_valid never rises, all outputs 0; in_ready=1 the first cycle after rst falls.
- Random: 1000 random a/b/cin against the reference model a+b+cin, checking cout, ovf, pout and gout, with random out_ready stalls.
